// File: rtl/matvec_pkg.sv
// Shared state encoding and sizing helpers for the matvec_array engine.
package matvec_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_FILL = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Width of ld_sel: codes 0..rows-1 address A rows, code rows addresses B.
    function automatic int sel_width(input int rows);
        return $clog2(rows + 1);
    endfunction

    // Cycles spent in CALC: the skew across rows plus one pass over the columns.
    function automatic int calc_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/matvec_array_mac_pe.sv
// One multiply-accumulate element of the skewed chain; forwards b and enable
// to its neighbour through registers.
module mac_pe #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    output logic                  en_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [ACC_WIDTH-1:0]  acc
);
    localparam int PW = 2 * DATA_WIDTH;

    logic [ACC_WIDTH-1:0] prod_ext;

    if (SIGNED != 0) begin : g_signed
        logic signed [PW-1:0] prod;
        // Size casts of signed operands sign-extend, so the product and its
        // widening to the accumulator keep two's-complement meaning.
        assign prod     = PW'($signed(a_in)) * PW'($signed(b_in));
        assign prod_ext = ACC_WIDTH'(prod);
    end else begin : g_unsigned
        logic [PW-1:0] prod;
        assign prod     = PW'(a_in) * PW'(b_in);
        assign prod_ext = ACC_WIDTH'(prod);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_out <= 1'b0;
            b_out  <= '0;
            acc    <= '0;
        end else begin
            en_out <= en_in;
            b_out  <= b_in;
            if (clr)
                acc <= '0;
            else if (en_in)
                acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/matvec_array.sv
// Matrix-vector engine: stream A rows and B into per-row buffers, run a
// skewed MAC chain, then hold C = A*B until the next job is requested.
module matvec_array
    import matvec_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SIGNED     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [sel_width(ROWS)-1:0] ld_sel,
    input  logic [DATA_WIDTH-1:0]      ld_data,
    input  logic                       reuse_a,
    input  logic                       next,
    output logic                       busy,
    output logic                       done,
    output logic                       c_valid,
    output logic [ROWS*ACC_WIDTH-1:0]  c_out
);
    localparam int SW   = sel_width(ROWS);
    localparam int CW   = $clog2(COLS + 1);
    localparam int IW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LAST = calc_len(ROWS, COLS) - 1;
    localparam int TW   = $clog2(LAST + 2);

    state_t                state;
    logic [TW-1:0]         t;
    logic [DATA_WIDTH-1:0] a_buf [ROWS][COLS];
    logic [DATA_WIDTH-1:0] b_buf [COLS];
    logic [CW-1:0]         wr_cnt [ROWS+1];
    logic [CW-1:0]         rd_cnt [ROWS+1];
    logic [ROWS:0]         full;
    logic                  sel_ok;
    logic                  wr_en;
    logic [IW-1:0]         wr_idx;
    logic                  clr;
    logic [ROWS:0]         en_chain;
    logic [DATA_WIDTH-1:0] b_chain [ROWS+1];
    logic [DATA_WIDTH-1:0] a_rd [ROWS];
    logic [ACC_WIDTH-1:0]  acc [ROWS];
    logic                  chain_unused;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can infer a latch.
    always_comb begin
        full = '0;
        for (int i = 0; i <= ROWS; i++)
            full[i] = (wr_cnt[i] == CW'(COLS));
    end

    // Codes above ROWS address nothing: they are accepted and dropped.
    assign sel_ok = (ld_sel <= SW'(ROWS));

    always_comb begin
        ld_ready = 1'b0;
        if (state == ST_FILL)
            ld_ready = sel_ok ? !full[ld_sel] : 1'b1;
    end

    assign wr_en  = ld_valid && ld_ready && sel_ok;
    assign wr_idx = wr_cnt[ld_sel][IW-1:0];

    // NOTE: buffer storage has no reset; the counters alone define which
    // entries are meaningful, so a reset discards contents without clearing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (ld_sel == SW'(ROWS))
                b_buf[wr_idx] <= ld_data;
            else
                a_buf[ld_sel[RW-1:0]][wr_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FILL;
            t     <= '0;
            done  <= 1'b0;
            for (int i = 0; i <= ROWS; i++) begin
                wr_cnt[i] <= '0;
                rd_cnt[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (&full) begin
                        state <= ST_CALC;
                        t     <= '0;
                    end else if (wr_en) begin
                        wr_cnt[ld_sel] <= wr_cnt[ld_sel] + CW'(1);
                    end
                end
                ST_CALC: begin
                    t <= t + TW'(1);
                    if (en_chain[0])
                        rd_cnt[ROWS] <= rd_cnt[ROWS] + CW'(1);
                    for (int r = 0; r < ROWS; r++)
                        if (en_chain[r])
                            rd_cnt[r] <= rd_cnt[r] + CW'(1);
                    if (t == TW'(LAST)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (next) begin
                        state        <= ST_FILL;
                        wr_cnt[ROWS] <= '0;
                        for (int i = 0; i <= ROWS; i++)
                            rd_cnt[i] <= '0;
                        // With reuse the A rows stay full and only B reloads.
                        if (!reuse_a)
                            for (int r = 0; r < ROWS; r++)
                                wr_cnt[r] <= '0;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    assign clr         = (state == ST_DONE) && next;
    assign en_chain[0] = (state == ST_CALC) && (rd_cnt[ROWS] != CW'(COLS));
    assign b_chain[0]  = b_buf[rd_cnt[ROWS][IW-1:0]];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        // Row r sees B[k] r cycles late, so its own pointer follows its enable.
        assign a_rd[r] = a_buf[r][rd_cnt[r][IW-1:0]];

        mac_pe #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .SIGNED    (SIGNED)
        ) u_pe (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .en_in (en_chain[r]),
            .b_in  (b_chain[r]),
            .a_in  (a_rd[r]),
            .en_out(en_chain[r+1]),
            .b_out (b_chain[r+1]),
            .acc   (acc[r])
        );

        assign c_out[r*ACC_WIDTH +: ACC_WIDTH] = acc[r];
    end

    assign chain_unused = ^{en_chain[ROWS], b_chain[ROWS]};
    assign busy         = (state == ST_CALC);
    assign c_valid      = (state == ST_DONE);

endmodule
